// File: rtl/comparator_serial_pkg.sv
// Shared types and merge rules for the digit-serial word comparator.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package comparator_serial_pkg;

    // Compare outcome of one digit or of a whole word.
    typedef logic [1:0] cmp_t;

    localparam cmp_t CMP_EQ = 2'd0;
    localparam cmp_t CMP_GT = 2'd1;
    localparam cmp_t CMP_LT = 2'd2;

    // Least-significant digit first: any later (more significant) difference wins.
    function automatic cmp_t merge_lsb(input cmp_t state, input cmp_t d);
        return (d != CMP_EQ) ? d : state;
    endfunction

    // Most-significant digit first: the first difference seen is final.
    function automatic cmp_t merge_msb(input cmp_t state, input cmp_t d);
        return (state != CMP_EQ) ? state : d;
    endfunction

endpackage

// File: rtl/comparator_serial_word_digit_cmp.sv
// Combinational magnitude compare of one DIGIT-bit slice of a and b.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows the inputs.
module digit_cmp
    import comparator_serial_pkg::*;
#(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             is_signed,
    output cmp_t             res
);

    logic gt_u;
    logic gt_s;

    assign gt_u = (a > b);
    assign gt_s = ($signed(a) > $signed(b));

    // Classify the digit pair; the signed view is used only for the sign-carrying digit.
    always_comb begin
        res = CMP_LT;
        if (a == b) begin
            res = CMP_EQ;
        end else if (is_signed ? gt_s : gt_u) begin
            res = CMP_GT;
        end
    end

endmodule

// File: rtl/comparator_serial_word.sv
// Digit-serial word comparator: folds DIGIT-bit beats into a registered eq/gt/lt word result.
// Latency: result and done appear 1 cycle after the beat carrying the last digit.
// Backpressure: none; every in_valid beat is accepted, idle cycles are simply gaps.
module comparator_serial_word
    import comparator_serial_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int DIGIT     = 4,
    parameter int MSB_FIRST = 0,
    parameter int SIGNED    = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_first,
    input  logic [DIGIT-1:0] a_digit,
    input  logic [DIGIT-1:0] b_digit,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt,
    output logic             err
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);
    // The digit holding bit WIDTH-1 arrives first when MSB-first, last otherwise.
    localparam logic [CNT_W-1:0] SIGN_CNT = (MSB_FIRST != 0) ? {CNT_W{1'b0}} : LAST_CNT;

    if ((WIDTH % DIGIT) != 0) begin : g_bad_cfg
        $error("comparator_serial_word: WIDTH must be a multiple of DIGIT");
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;
    cmp_t             state_q, state_d;
    logic             eq_q, eq_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             start;
    logic [CNT_W-1:0] cnt_eff;
    logic             sign_digit;
    cmp_t             d_cmp;
    cmp_t             next_state;

    // A beat restarts the word when flagged first or when nothing is in flight.
    assign start      = in_valid && (in_first || (cnt_q == '0));
    assign cnt_eff    = start ? '0 : cnt_q;
    assign sign_digit = (SIGNED != 0) && (cnt_eff == SIGN_CNT);

    digit_cmp #(
        .DIGIT(DIGIT)
    ) u_digit_cmp (
        .a        (a_digit),
        .b        (b_digit),
        .is_signed(sign_digit),
        .res      (d_cmp)
    );

    // Fold the current digit into the running word state; digit 0 discards history.
    always_comb begin
        next_state = d_cmp;
        if (cnt_eff != '0) begin
            if (MSB_FIRST != 0) begin
                next_state = merge_msb(state_q, d_cmp);
            end else begin
                next_state = merge_lsb(state_q, d_cmp);
            end
        end
    end

    // Advance the digit counter and publish the word result on its last digit.
    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        done_d  = 1'b0;
        err_d   = in_valid && in_first && (cnt_q != '0);
        if (in_valid) begin
            if (cnt_eff == LAST_CNT) begin
                cnt_d   = '0;
                state_d = CMP_EQ;
                eq_d    = (next_state == CMP_EQ);
                gt_d    = (next_state == CMP_GT);
                lt_d    = (next_state == CMP_LT);
                done_d  = 1'b1;
            end else begin
                cnt_d   = cnt_eff + 1'b1;
                state_d = next_state;
            end
        end
    end

    // State and output registers; reset drops any partial word and reports equality.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            state_q <= CMP_EQ;
            eq_q    <= 1'b1;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign busy = (cnt_q != '0);
    assign done = done_q;
    assign eq   = eq_q;
    assign gt   = gt_q;
    assign lt   = lt_q;
    assign err  = err_q;

endmodule
